// File: rtl/i2c_pkg.sv
// +----------------------------------------------------------------------+
// | i2c_pkg : encodings shared by the I2C target and controller          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    localparam int   c_RW_BIT    = 0;
    localparam logic c_READ      = 1'b1;
    localparam logic c_WRITE     = 1'b0;
    localparam logic [3:0] c_LAST_BIT = 4'd7;
    localparam logic [3:0] c_BYTE_DONE = 4'd8;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// +----------------------------------------------------------------------+
// | i2c_sync_edge : 2-FF synchronizer with level and edge outputs        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Preset high so an idle (pulled-up) bus produces no edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// +----------------------------------------------------------------------+
// | i2c_target : 7-bit address I2C target with byte RX/TX to the fabric  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42,
    parameter int         HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       rw
);

    import i2c_pkg::*;

    localparam int c_HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_hold_fire;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (SCL),
        .level (w_scl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (SDA),
        .level (w_sda),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // One-shot delay from each SCL fall to the moment our SDA may change.
    logic            r_hold_act;
    logic [c_HW-1:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_act <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_start || w_stop) begin
            r_hold_act <= 1'b0;
        end else if (w_scl_fall) begin
            r_hold_act <= 1'b1;
            r_hold_cnt <= c_HW'(HOLD);
        end else if (r_hold_act) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
            if (r_hold_cnt == c_HW'(1))
                r_hold_act <= 1'b0;
        end
    end

    assign w_hold_fire = r_hold_act && (r_hold_cnt == c_HW'(1));

    i2c_state_t r_state, w_state_d;
    logic [3:0] r_bit_cnt, w_bit_cnt_d;
    logic [7:0] r_shift, w_shift_d, w_shift_in;
    logic       r_sda_low, w_sda_low_d;
    logic       r_busy, w_busy_d;
    logic       r_rw, w_rw_d;
    logic [7:0] r_rx_data, w_rx_data_d;
    logic       r_rx_valid, w_rx_valid_d;
    logic       r_tx_req, w_tx_req_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_shift    <= w_shift_d;
            r_sda_low  <= w_sda_low_d;
            r_busy     <= w_busy_d;
            r_rw       <= w_rw_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_valid <= w_rx_valid_d;
            r_tx_req   <= w_tx_req_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_bit_cnt_d  = r_bit_cnt;
        w_shift_d    = r_shift;
        w_sda_low_d  = r_sda_low;
        w_busy_d     = r_busy;
        w_rw_d       = r_rw;
        w_rx_data_d  = r_rx_data;
        w_rx_valid_d = 1'b0;
        w_tx_req_d   = 1'b0;
        w_shift_in   = {r_shift[6:0], w_sda};

        if (w_stop) begin
            w_state_d   = ST_IDLE;
            w_bit_cnt_d = '0;
            w_sda_low_d = 1'b0;
            w_busy_d    = 1'b0;
        end else if (w_start) begin
            w_state_d   = ST_ADDR;
            w_bit_cnt_d = '0;
            w_sda_low_d = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_shift_in;
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_bit_cnt_d = '0;
                            if (w_shift_in[7:1] == ADDR) begin
                                w_rw_d    = w_shift_in[c_RW_BIT];
                                w_busy_d  = 1'b1;
                                w_state_d = ST_ADDR_ACK;
                            end else begin
                                w_state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                // ACK phases: the first hold event starts the low drive,
                // the second (after the 9th fall) ends it.
                ST_ADDR_ACK: begin
                    if (w_hold_fire) begin
                        if (!r_sda_low) begin
                            w_sda_low_d = 1'b1;
                        end else if (r_rw == c_READ) begin
                            w_tx_req_d  = 1'b1;
                            w_shift_d   = tx_data;
                            w_sda_low_d = ~tx_data[7];
                            w_bit_cnt_d = '0;
                            w_state_d   = ST_TX;
                        end else begin
                            w_sda_low_d = 1'b0;
                            w_bit_cnt_d = '0;
                            w_state_d   = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (w_scl_rise) begin
                        w_shift_d   = w_shift_in;
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_rx_data_d  = w_shift_in;
                            w_rx_valid_d = 1'b1;
                            w_bit_cnt_d  = '0;
                            w_state_d    = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (w_hold_fire) begin
                        if (!r_sda_low) begin
                            w_sda_low_d = 1'b1;
                        end else begin
                            w_sda_low_d = 1'b0;
                            w_state_d   = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_d = r_bit_cnt + 4'd1;
                    end else if (w_hold_fire) begin
                        if (r_bit_cnt == c_BYTE_DONE) begin
                            w_sda_low_d = 1'b0;
                            w_bit_cnt_d = '0;
                            w_state_d   = ST_TX_ACK;
                        end else begin
                            w_sda_low_d = ~r_shift[6];
                            w_shift_d   = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                // Only the 9th fall can fire here, so reaching it means ACK.
                ST_TX_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_d = ST_IGNORE;
                    end else if (w_hold_fire) begin
                        w_tx_req_d  = 1'b1;
                        w_shift_d   = tx_data;
                        w_sda_low_d = ~tx_data[7];
                        w_bit_cnt_d = '0;
                        w_state_d   = ST_TX;
                    end
                end
                default: begin
                    w_sda_low_d = 1'b0;
                end
            endcase
        end
    end

    assign SDA      = r_sda_low ? 1'b0 : 1'bz;
    assign tx_req   = r_tx_req;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign rw       = r_rw;

endmodule

`default_nettype wire
